rotate_stage: RTL and testbench

- Rho (lane-rotation) stage of the encoder; sits directly upstream of the permute stage.
- Accepts one full 1600-bit state as a stream of 64 slices of 25 bits (slice z = bit z of every lane) and buffers the whole state.
- Then emits 64 rotated slices, each with its line index, ready for the permute datapath's 25-bit per-line register.
- Rotation crosses slices, so the stage must buffer the full state; it cannot be done per slice.

---
 rtl/rotate_stage.sv | 173 +++++++++++++++++
 tb/tb_rotate_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rotate_stage.sv
// Rho lane-rotation stage: buffers a full 1600-bit state arriving as 64 slices
// of 25 lanes, then streams out 64 rotated slices tagged with their index.
module rotate_stage #(
    parameter int unsigned SLICES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [24:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [24:0] out_data,
    output logic [5:0]  out_index,
    output logic        busy
);

    localparam int unsigned IDX_W = 6;
    localparam int unsigned LANES = 25;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Constant per-lane rotation amounts, lane i = 5*y + x
    function automatic logic [IDX_W-1:0] rho_off(input int lane);
        case (lane)
            0:       return 6'd0;
            1:       return 6'd1;
            2:       return 6'd62;
            3:       return 6'd28;
            4:       return 6'd27;
            5:       return 6'd36;
            6:       return 6'd44;
            7:       return 6'd6;
            8:       return 6'd55;
            9:       return 6'd20;
            10:      return 6'd3;
            11:      return 6'd10;
            12:      return 6'd43;
            13:      return 6'd25;
            14:      return 6'd39;
            15:      return 6'd41;
            16:      return 6'd45;
            17:      return 6'd15;
            18:      return 6'd21;
            19:      return 6'd8;
            20:      return 6'd18;
            21:      return 6'd2;
            22:      return 6'd61;
            23:      return 6'd56;
            24:      return 6'd14;
            default: return 6'd0;
        endcase
    endfunction

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       wr_cnt_q, wr_cnt_d;
    logic [IDX_W-1:0]       rd_cnt_q, rd_cnt_d;
    logic [LANES-1:0]       mem_q [SLICES];
    logic [LANES-1:0]       mem_d [SLICES];
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [LANES-1:0]       out_data_q, out_data_d;
    logic [IDX_W-1:0]       out_index_q, out_index_d;
    logic                   busy_q, busy_d;

    logic                   wr_fire_c;
    logic                   rd_fire_c;
    logic [IDX_W-1:0]       view_idx_c;
    logic [LANES-1:0]       rot_c;

    assign wr_fire_c = in_valid && in_ready_q && (state_q == ST_LOAD);
    assign rd_fire_c = out_valid_q && out_ready;

    // Rotated slice for the index presented next; the slice being written this
    // cycle is bypassed so the first output can be registered on the last load edge.
    always_comb begin
        logic [IDX_W-1:0] src;
        src        = '0;
        rot_c      = '0;
        view_idx_c = (state_q == ST_DRAIN) ? IDX_W'(rd_cnt_q + 6'd1) : '0;
        for (int i = 0; i < int'(LANES); i++) begin
            src      = IDX_W'(view_idx_c - rho_off(i));
            rot_c[i] = (wr_fire_c && (src == wr_cnt_q)) ? in_data[i] : mem_q[src][i];
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        mem_d       = mem_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;

        case (state_q)
            ST_LOAD: begin
                if (wr_fire_c) begin
                    mem_d[wr_cnt_q] = in_data;
                    wr_cnt_d        = IDX_W'(wr_cnt_q + 6'd1);
                    if (wr_cnt_q == LAST_IDX) begin
                        state_d     = ST_DRAIN;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                        rd_cnt_d    = '0;
                        out_index_d = '0;
                        out_data_d  = rot_c;
                    end
                end
            end
            ST_DRAIN: begin
                if (rd_fire_c) begin
                    if (rd_cnt_q == LAST_IDX) begin
                        state_d     = ST_LOAD;
                        rd_cnt_d    = '0;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                        out_index_d = '0;
                        out_data_d  = '0;
                    end else begin
                        rd_cnt_d    = IDX_W'(rd_cnt_q + 6'd1);
                        out_index_d = IDX_W'(rd_cnt_q + 6'd1);
                        out_data_d  = rot_c;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        busy_d = (state_d == ST_DRAIN) || (wr_cnt_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            for (int s = 0; s < int'(SLICES); s++) begin
                mem_q[s] <= '0;
            end
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            mem_q       <= mem_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rotate_stage.sv
// Directed bench for rotate_stage: hand-computed slices plus a rho reference
// model for random states, with backpressure, junk input during drain and reset abort.
module tb_rotate_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] out_data;
    logic [5:0]  out_index;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int rho_r [25] = '{0, 1, 62, 28, 27,
                       36, 44, 6, 55, 20,
                       3, 10, 43, 25, 39,
                       41, 45, 15, 21, 8,
                       18, 2, 61, 56, 14};

    logic [24:0] st [64];
    logic [24:0] ex [64];

    rotate_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [24:0] rho_model(input logic [24:0] s [64], input int z);
        logic [24:0] r;
        r = '0;
        for (int i = 0; i < 25; i++) begin
            r[i] = s[((z - rho_r[i]) % 64 + 64) % 64][i];
        end
        return r;
    endfunction

    task automatic load_state(input logic [24:0] s [64], input bit gaps);
        for (int z = 0; z < 64; z++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                in_valid = 1'b0;
                in_data  = 25'($urandom());
                step();
                chk("idle_no_out", 32'(out_valid), 32'd0);
            end
            in_valid = 1'b1;
            in_data  = s[z];
            chk("load_in_ready", 32'(in_ready), 32'd1);
            chk("load_no_out", 32'(out_valid), 32'd0);
            step();
            if (z < 63) chk("load_busy", 32'(busy), 32'd1);
        end
        in_valid = 1'b0;
        in_data  = '0;
        chk("first_out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic drain_state(input logic [24:0] e [64], input bit rnd_ready, input bit junk);
        for (int z = 0; z < 64; z++) begin
            int stalls;
            bit done;
            stalls = 0;
            done   = 1'b0;
            while (!done) begin
                out_ready = (rnd_ready && stalls < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
                if (junk) begin
                    in_valid = 1'b1;
                    in_data  = 25'($urandom());
                end
                chk("drain_valid", 32'(out_valid), 32'd1);
                chk("drain_index", 32'(out_index), 32'(z));
                chk("drain_data", 32'(out_data), 32'(e[z]));
                chk("drain_in_ready", 32'(in_ready), 32'd0);
                chk("drain_busy", 32'(busy), 32'd1);
                done = out_ready;
                stalls++;
                step();
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("post_drain_valid", 32'(out_valid), 32'd0);
        chk("post_drain_in_ready", 32'(in_ready), 32'd1);
        chk("post_drain_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_index", 32'(out_index), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();

        // Lane 0 set in slice 7 only: offset 0, lands at index 7
        for (int z = 0; z < 64; z++) begin st[z] = '0; ex[z] = '0; end
        st[7] = 25'h0000001;
        ex[7] = 25'h0000001;
        load_state(st, 1'b0);
        drain_state(ex, 1'b0, 1'b0);

        // Lane 1 at slice 0 -> index 1; lane 2 at slice 5 -> index 3 (wraps)
        for (int z = 0; z < 64; z++) begin st[z] = '0; ex[z] = '0; end
        st[0] = 25'h0000002;
        st[5] = 25'h0000004;
        ex[1] = 25'h0000002;
        ex[3] = 25'h0000004;
        load_state(st, 1'b0);
        drain_state(ex, 1'b0, 1'b0);

        // All ones survives any rotation
        for (int z = 0; z < 64; z++) begin st[z] = 25'h1FFFFFF; ex[z] = 25'h1FFFFFF; end
        load_state(st, 1'b0);
        drain_state(ex, 1'b0, 1'b0);

        // Random state, input gaps, random backpressure, junk input during drain
        for (int z = 0; z < 64; z++) st[z] = 25'($urandom());
        for (int z = 0; z < 64; z++) ex[z] = rho_model(st, z);
        load_state(st, 1'b1);
        drain_state(ex, 1'b1, 1'b1);

        // Abort after 30 slices
        for (int z = 0; z < 30; z++) begin
            in_valid = 1'b1;
            in_data  = 25'($urandom());
            step();
        end
        in_valid = 1'b0;
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("abort_no_out", 32'(out_valid), 32'd0);
            chk("abort_idle_busy", 32'(busy), 32'd0);
        end

        // Fresh state after abort drains from index 0
        for (int z = 0; z < 64; z++) st[z] = 25'($urandom());
        for (int z = 0; z < 64; z++) ex[z] = rho_model(st, z);
        load_state(st, 1'b0);
        drain_state(ex, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
